// File: rtl/adder_tree_feeder.sv
// ---------------------------------------------------------------------------
// adder_tree_feeder
//
// Purpose: collects NI single-precision operand words from a valid/ready
// stream into one wide packed bus, starts an external adder tree on that bus,
// captures the tree's summation, and offers it on a valid/ready result port.
// Operand and result words pass through untouched; no arithmetic is done here.
//
// Parameters:
//   NI       number of 32-bit operands per reduction (even, >= 2)
//   TIMEOUT  watchdog limit in RUN cycles (only with ADDER_TIMEOUT_EN)
//
// Optional feature macro: ADDER_TIMEOUT_EN
//   Defined   -> a watchdog aborts a reduction that does not finish within
//                TIMEOUT cycles, returns a quiet NaN and sets timeout_err.
//   Undefined -> RUN waits indefinitely and timeout_err is tied low.
//
// Ports:
//   clk          single clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   in_valid     operand word offered
//   in_data      operand word (IEEE-754 single)
//   in_ready     operand accepted when in_valid && in_ready
//   ExE_start    start level to the adder tree
//   inputs       packed operand bus; word k sits at [32*(NI-k)-1 -: 32]
//   summation    adder tree result
//   ExE_finish   adder tree done level
//   res_valid    result available
//   res_data     captured summation (or quiet NaN after a watchdog abort)
//   res_ready    result consumed when res_valid && res_ready
//   busy         high in every state except FILL
//   timeout_err  sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module adder_tree_feeder #(
  parameter int NI      = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              ExE_start,
  output logic [NI*32-1:0]  inputs,
  input  logic [31:0]       summation,
  input  logic              ExE_finish,
  output logic              res_valid,
  output logic [31:0]       res_data,
  input  logic              res_ready,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(NI);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NI - 1);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    RESULT,
    DRAIN
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] fill_cnt;
  logic [31:0]      slot [NI];
  logic             accept;
  logic             last_accept;
  logic             wd_expired;

  // Reject illegal configurations at elaboration time.
  if (NI < 2 || (NI % 2) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("adder_tree_feeder: NI must be even and >= 2, TIMEOUT must be >= 1");
  end

  assign accept      = in_valid && (state == FILL);
  assign last_accept = accept && (fill_cnt == CNT_LAST);

  // Operand k is stored in slot k; slot 0 lands in the most significant word
  // of the bus so the first word received is the leftmost operand.
  for (genvar k = 0; k < NI; k++) begin : g_pack
    assign inputs[32*(NI-k)-1 -: 32] = slot[k];
  end

`ifdef ADDER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [WD_W-1:0] wd_cnt;

  // Watchdog counts RUN cycles without a finish; it restarts on every entry
  // to RUN. Expiry lands on the TIMEOUT-th RUN cycle, and a finish seen on
  // that same cycle still wins over the abort.
  always_ff @(posedge clk) begin
    if (!rst_n || state != RUN) begin
      wd_cnt <= '0;
    end else if (!ExE_finish) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expired = (state == RUN) && !ExE_finish && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (wd_expired) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. ExE_finish is deliberately ignored in FILL so that a
  // late finish from an aborted reduction cannot disturb a new batch.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (last_accept) state_next = RUN;
      RUN:     if (ExE_finish || wd_expired) state_next = RESULT;
      RESULT:  if (res_ready) state_next = ExE_finish ? DRAIN : FILL;
      DRAIN:   if (!ExE_finish) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Handshake outputs decoded from the state alone.
  always_comb begin
    in_ready  = 1'b0;
    ExE_start = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      RUN:     ExE_start = 1'b1;
      RESULT:  res_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture. Slots only change on an accept in FILL, so the bus is
  // frozen from RUN entry until the first word of the next batch arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_cnt <= '0;
      for (int k = 0; k < NI; k++) begin
        slot[k] <= '0;
      end
    end else if (accept) begin
      slot[fill_cnt] <= in_data;
      fill_cnt       <= last_accept ? '0 : fill_cnt + 1'b1;
    end
  end

  // Result capture on the first finish seen in RUN (or the watchdog abort).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data <= '0;
    end else if (state == RUN) begin
      if (ExE_finish) begin
        res_data <= summation;
      end
`ifdef ADDER_TIMEOUT_EN
      else if (wd_expired) begin
        res_data <= QNAN;
      end
`endif
    end
  end

endmodule

// File: tb/tb_adder_tree_feeder.sv
// ---------------------------------------------------------------------------
// tb_adder_tree_feeder
//
// Self-checking bench for adder_tree_feeder (NI=128, TIMEOUT=50). A small
// adder-tree emulator and a result consumer react to the DUT; a behavioural
// model tracks the batch/result life cycle and one compare process checks
// every output on every falling edge, plus a few hand-computed pins.
// Honors ADDER_TIMEOUT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_adder_tree_feeder;

  localparam int NI = 128;
  localparam int TO = 50;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  localparam int PIN_RESET    = 1;
  localparam int PIN_ONES     = 2;
  localparam int PIN_COUNT    = 3;
  localparam int PIN_BACKPRES = 4;
  localparam int PIN_ABORT    = 5;
  localparam int PIN_WATCHDOG = 6;
  localparam int PIN_WAITS    = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_ready;
  logic              ExE_start;
  logic [NI*32-1:0]  inputs;
  logic [31:0]       summation = '0;
  logic              ExE_finish = 1'b0;
  logic              res_valid;
  logic [31:0]       res_data;
  logic              res_ready = 1'b0;
  logic              busy;
  logic              timeout_err;

  int errors = 0;
  int checks = 0;

  // Stimulus-owned controls for the tree emulator and consumer.
  int          tree_enable  = 1;
  int          tree_latency = 5;
  int          tree_hold    = 1;
  logic [31:0] tree_sum     = '0;
  int          pulse_seq    = 0;
  int          pulse_len    = 0;
  int          rr_delay     = 0;
  int          fill_iters   = 0;
  int          stim_expired = 0;
  int          pin_code     = 0;
  int          pin_seq      = 0;

  // Behavioural model state.
  typedef enum int {M_COLLECT, M_REDUCE, M_OFFER, M_SETTLE} mphase_t;
  mphase_t     m_phase = M_COLLECT;
  int          m_live  = 0;
  int          m_count = 0;
  int          m_run   = 0;
  logic [31:0] m_slot [NI];
  logic [31:0] m_res  = '0;
  logic        m_tout = 1'b0;

  always #5 clk = ~clk;

  adder_tree_feeder #(.NI(NI), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ExE_start(ExE_start), .inputs(inputs),
    .summation(summation), .ExE_finish(ExE_finish), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready), .busy(busy),
    .timeout_err(timeout_err)
  );

  // Adder tree emulator: raises finish tree_latency cycles after it first
  // sees start, holds it tree_hold cycles; pulse requests force a finish.
  initial begin : tree
    int wait_cnt;
    int hold_left;
    int seen_pulse;
    wait_cnt = 0;
    hold_left = 0;
    seen_pulse = 0;
    forever begin
      @(posedge clk); #1;
      if (hold_left > 0) hold_left--;
      if (pulse_seq != seen_pulse) begin
        seen_pulse = pulse_seq;
        hold_left  = pulse_len;
        summation  = tree_sum;
      end else if (hold_left == 0 && tree_enable != 0 && ExE_start === 1'b1) begin
        wait_cnt++;
        if (wait_cnt >= tree_latency) begin
          hold_left = tree_hold;
          wait_cnt  = 0;
          summation = tree_sum;
        end
      end else begin
        wait_cnt = 0;
      end
      ExE_finish = (hold_left > 0);
    end
  end

  // Result consumer: keeps res_valid waiting rr_delay cycles, then accepts.
  initial begin : consumer
    int waited;
    waited = 0;
    forever begin
      @(posedge clk); #1;
      if (res_valid === 1'b1 && !res_ready) begin
        if (waited >= rr_delay) begin
          res_ready = 1'b1;
          waited    = 0;
        end else begin
          waited++;
        end
      end else begin
        res_ready = 1'b0;
      end
    end
  end

  // Behavioural model: batches of NI words, then one reduction, one offered
  // result, and a wait for finish to drop if it is still high at hand-off.
  initial begin : model
    foreach (m_slot[k]) m_slot[k] = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_phase = M_COLLECT;
        m_count = 0;
        foreach (m_slot[k]) m_slot[k] = '0;
        m_res  = '0;
        m_tout = 1'b0;
        m_live = 1;
      end else if (m_live != 0) begin
        case (m_phase)
          M_COLLECT: if (in_valid) begin
            m_slot[m_count] = in_data;
            m_count++;
            if (m_count == NI) begin
              m_count = 0;
              m_run   = 0;
              m_phase = M_REDUCE;
            end
          end
          M_REDUCE: if (ExE_finish) begin
            m_res   = summation;
            m_phase = M_OFFER;
          end else begin
            m_run++;
`ifdef ADDER_TIMEOUT_EN
            if (m_run == TO) begin
              m_res   = QNAN;
              m_tout  = 1'b1;
              m_phase = M_OFFER;
            end
`endif
          end
          M_OFFER:  if (res_ready) m_phase = ExE_finish ? M_SETTLE : M_COLLECT;
          M_SETTLE: if (!ExE_finish) m_phase = M_COLLECT;
          default:  m_phase = M_COLLECT;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: model checks every cycle, plus requested pins.
  initial begin : compare
    int start_run, rv_run, last_start_len, last_rv_len, pin_done, bad, nz;
    logic [NI*32-1:0] exp_bus, sh;
    logic [31:0] got;
    start_run = 0; rv_run = 0; last_start_len = 0; last_rv_len = 0; pin_done = 0;
    forever begin
      @(negedge clk);
      if (ExE_start === 1'b1) start_run++;
      else if (start_run > 0) begin last_start_len = start_run; start_run = 0; end
      if (res_valid === 1'b1) rv_run++;
      else if (rv_run > 0) begin last_rv_len = rv_run; rv_run = 0; end

      if (m_live != 0) begin
        checkOutput("in_ready",    {31'b0, in_ready},    {31'b0, m_phase == M_COLLECT});
        checkOutput("ExE_start",   {31'b0, ExE_start},   {31'b0, m_phase == M_REDUCE});
        checkOutput("res_valid",   {31'b0, res_valid},   {31'b0, m_phase == M_OFFER});
        checkOutput("busy",        {31'b0, busy},        {31'b0, m_phase != M_COLLECT});
        checkOutput("timeout_err", {31'b0, timeout_err}, {31'b0, m_tout});
        checkOutput("res_data",    res_data,             m_res);
        exp_bus = '0;
        for (int k = 0; k < NI; k++) begin
          exp_bus = exp_bus << 32;
          exp_bus[31:0] = m_slot[k];
        end
        checks++;
        if (inputs !== exp_bus) begin
          errors++;
          bad = -1;
          got = '0;
          for (int k = 0; k < NI; k++) begin
            sh = inputs >> (32 * (NI - 1 - k));
            if (bad < 0 && sh[31:0] !== m_slot[k]) begin
              bad = k;
              got = sh[31:0];
            end
          end
          $display("[TB] FAIL inputs word %0d: got %h expected %h at %0t",
                   bad, got, (bad >= 0) ? m_slot[bad] : 32'h0, $time);
        end
      end

      if (pin_seq != pin_done) begin
        pin_done = pin_seq;
        case (pin_code)
          PIN_RESET: begin
            nz = 0;
            for (int k = 0; k < NI; k++) begin
              sh = inputs >> (32 * k);
              if (sh[31:0] !== 32'h0) nz++;
            end
            checkOutput("reset_in_ready",   {31'b0, in_ready},    32'd1);
            checkOutput("reset_start",      {31'b0, ExE_start},   32'd0);
            checkOutput("reset_res_valid",  {31'b0, res_valid},   32'd0);
            checkOutput("reset_busy",       {31'b0, busy},        32'd0);
            checkOutput("reset_res_data",   res_data,             32'd0);
            checkOutput("reset_timeout",    {31'b0, timeout_err}, 32'd0);
            checkOutput("reset_bus_nonzero_words", 32'(nz),       32'd0);
          end
          PIN_ONES: begin
            checkOutput("ones_start_len", 32'(last_start_len), 32'd20);
            checkOutput("ones_sum",       res_data,            32'h43000000);
            checkOutput("ones_rv_len",    32'(last_rv_len),    32'd1);
          end
          PIN_COUNT: begin
            checkOutput("count_fill_cycles", 32'(fill_iters),         32'd256);
            checkOutput("count_first_word",  inputs[NI*32-1 -: 32],   32'd0);
            checkOutput("count_last_word",   inputs[31:0],            32'd127);
          end
          PIN_BACKPRES: checkOutput("backpressure_rv_len", 32'(last_rv_len), 32'd10);
          PIN_ABORT: begin
            checkOutput("abort_start",     {31'b0, ExE_start}, 32'd0);
            checkOutput("abort_in_ready",  {31'b0, in_ready},  32'd1);
            checkOutput("abort_res_valid", {31'b0, res_valid}, 32'd0);
          end
          PIN_WATCHDOG: begin
`ifdef ADDER_TIMEOUT_EN
            checkOutput("wd_start",   {31'b0, ExE_start},   32'd0);
            checkOutput("wd_err",     {31'b0, timeout_err}, 32'd1);
            checkOutput("wd_nan",     res_data,             QNAN);
`else
            checkOutput("wd_start",   {31'b0, ExE_start},   32'd1);
            checkOutput("wd_err",     {31'b0, timeout_err}, 32'd0);
`endif
          end
          PIN_WAITS: checkOutput("bounded_waits_expired", 32'(stim_expired), 32'd0);
          default: ;
        endcase
      end
    end
  end

  task automatic requestPin(input int code);
    @(posedge clk); #1;
    pin_code = code;
    pin_seq++;
    @(negedge clk); #1;
  endtask

  // Feeds one batch of NI words. pattern: 0 always valid, 1 toggling
  // starting low, 2 random. dmode: 0 ones, 1 index, 2 random.
  task automatic applyStimulus(input int pattern, input int dmode, output int iters);
    int   k;
    logic v;
    logic acc;
    k = 0;
    iters = 0;
    while (k < NI && iters < 4000) begin
      case (pattern)
        0:       v = 1'b1;
        1:       v = (iters % 2) == 1;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      case (dmode)
        0:       in_data = 32'h3F800000;
        1:       in_data = 32'(k);
        default: in_data = $urandom;
      endcase
      acc = v && (in_ready === 1'b1);
      @(posedge clk); #1;
      iters++;
      if (acc) k++;
    end
    in_valid = 1'b0;
    if (k < NI) stim_expired++;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) stim_expired++;
  endtask

  task automatic setTree(input int lat, input int hold, input int rrd, input logic [31:0] sum);
    tree_latency = lat;
    tree_hold    = hold;
    rr_delay     = rrd;
    tree_sum     = sum;
  endtask

  initial begin : stimulus
    int it;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    requestPin(PIN_RESET);

    $display("[TB] all-ones batch, tree latency 20");
    setTree(20, 1, 0, 32'h43000000);
    applyStimulus(0, 0, it);
    waitIdle();
    requestPin(PIN_ONES);

    $display("[TB] index batch with toggling valid");
    setTree(10, 1, 1, $urandom);
    applyStimulus(1, 1, fill_iters);
    requestPin(PIN_COUNT);
    waitIdle();

    $display("[TB] result backpressure");
    setTree(3, 5, 9, $urandom);
    applyStimulus(2, 2, it);
    waitIdle();
    requestPin(PIN_BACKPRES);

    $display("[TB] finish outlasts result handshake");
    setTree(4, 15, 2, $urandom);
    applyStimulus(2, 2, it);
    waitIdle();

    $display("[TB] random batches");
    for (int b = 0; b < 4; b++) begin
      setTree($urandom_range(1, 30), $urandom_range(1, 8), $urandom_range(0, 6), $urandom);
      applyStimulus(2, 2, it);
      waitIdle();
    end

    $display("[TB] reset mid-reduction then late finish");
    tree_enable = 0;
    applyStimulus(0, 2, it);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    requestPin(PIN_ABORT);
    tree_sum  = $urandom;
    pulse_len = 3;
    pulse_seq++;
    repeat (8) @(posedge clk);
    #1 tree_enable = 1;
    setTree(7, 2, 1, $urandom);
    applyStimulus(2, 2, it);
    waitIdle();

    $display("[TB] tree never finishes");
    tree_enable = 0;
    rr_delay    = 0;
    applyStimulus(0, 2, it);
    repeat (TO + 10) @(posedge clk);
    #1;
    requestPin(PIN_WATCHDOG);
    tree_sum  = $urandom;
    pulse_len = 1;
    pulse_seq++;
    repeat (3) @(posedge clk);
    #1;
    waitIdle();
    tree_enable = 1;
    repeat (5) @(posedge clk);
    #1;

    requestPin(PIN_WAITS);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : global_guard
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] global timeout");
  end

endmodule
